// File: rtl/slurm32_cpu_writeback_lq_pkg.sv
// Shared SLURM32 writeback decode: link register numbers, instruction match patterns,
// register field extraction and load-data alignment.
package slurm32_cpu_writeback_lq_pkg;

  localparam int LINK_REGISTER           = 15;
  localparam int INTERRUPT_LINK_REGISTER = 14;

  // Major opcode in [31:28]; [27] is the link / signed flag; fields dest [11:8], src [7:4], src2 [3:0]
  localparam logic [31:0] INSTRUCTION_CASEX_ALU_SINGLE_REG = 32'b0001_????_????_????_????_????_????_????;
  localparam logic [31:0] INSTRUCTION_CASEX_ALU_REG_REG    = 32'b0010_????_????_????_????_????_????_????;
  localparam logic [31:0] INSTRUCTION_CASEX_ALU_REG_IMM    = 32'b0011_????_????_????_????_????_????_????;
  localparam logic [31:0] INSTRUCTION_CASEX_BRANCH         = 32'b0100_????_????_????_????_????_????_????;
  localparam logic [31:0] INSTRUCTION_CASEX_COND_ALU       = 32'b0101_????_????_????_????_????_????_????;
  localparam logic [31:0] INSTRUCTION_CASEX_LOAD           = 32'b0110_????_????_????_????_????_????_????;

  typedef enum logic [2:0] {
    WB_NONE,
    WB_SRC2,
    WB_DEST,
    WB_LINK,
    WB_COND_SRC,
    WB_LOAD
  } wb_kind_t;

  function automatic logic [7:0] reg_dest_from_ins(input logic [31:0] ins);
    return {4'b0000, ins[11:8]};
  endfunction

  function automatic logic [7:0] reg_src_from_ins(input logic [31:0] ins);
    return {4'b0000, ins[7:4]};
  endfunction

  function automatic logic [7:0] reg_src2_from_ins(input logic [31:0] ins);
    return {4'b0000, ins[3:0]};
  endfunction

  function automatic logic is_branch_link_from_ins(input logic [31:0] ins);
    return ins[27];
  endfunction

  function automatic logic is_load_signed_from_ins(input logic [31:0] ins);
    return ins[27];
  endfunction

  function automatic wb_kind_t classify_from_ins(input logic [31:0] ins);
    wb_kind_t k;
    k = WB_NONE;
    casez (ins)
      INSTRUCTION_CASEX_ALU_SINGLE_REG: k = WB_SRC2;
      INSTRUCTION_CASEX_ALU_REG_REG:    k = WB_DEST;
      INSTRUCTION_CASEX_ALU_REG_IMM:    k = WB_DEST;
      INSTRUCTION_CASEX_BRANCH:         k = is_branch_link_from_ins(ins) ? WB_LINK : WB_NONE;
      INSTRUCTION_CASEX_COND_ALU:       k = WB_COND_SRC;
      INSTRUCTION_CASEX_LOAD:           k = WB_LOAD;
      default:                          k = WB_NONE;
    endcase
    return k;
  endfunction

  // Mask bit i selects byte lane i (bits 8i+7:8i); unrecognised masks fall back to the full word
  function automatic logic [31:0] load_align(input logic [31:0] d, input logic [3:0] m,
                                             input logic s);
    logic [31:0] r;
    r = d;
    case (m)
      4'b0011: r = {{16{s & d[15]}}, d[15:0]};
      4'b1100: r = {{16{s & d[31]}}, d[31:16]};
      4'b0001: r = {{24{s & d[7]}},  d[7:0]};
      4'b0010: r = {{24{s & d[15]}}, d[15:8]};
      4'b0100: r = {{24{s & d[23]}}, d[23:16]};
      4'b1000: r = {{24{s & d[31]}}, d[31:24]};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/slurm32_wb_load_queue.sv
// In-order pending-load FIFO with full/empty flags and a parallel compare of
// caller-supplied register selects against every pending load destination.
module slurm32_wb_load_queue #(
  parameter int REGISTER_BITS = 8,
  parameter int DEPTH         = 2,
  parameter int NUM_CMP       = 1
) (
  input  logic                                   CLK,
  input  logic                                   RSTb,
  input  logic                                   push,
  input  logic [REGISTER_BITS-1:0]               push_dest,
  input  logic [3:0]                             push_mask,
  input  logic                                   push_signed,
  input  logic                                   pop,
  output logic [REGISTER_BITS-1:0]               head_dest,
  output logic [3:0]                             head_mask,
  output logic                                   head_signed,
  output logic                                   full,
  output logic                                   empty,
  input  logic [NUM_CMP-1:0][REGISTER_BITS-1:0]  cmp_sel,
  output logic [NUM_CMP-1:0]                     cmp_hit
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [REGISTER_BITS-1:0] dest_q   [DEPTH];
  logic [3:0]               mask_q   [DEPTH];
  logic                     signed_q [DEPTH];
  logic [DEPTH-1:0]         valid_q;
  logic [PTR_W-1:0]         wr_ptr, rd_ptr;
  logic [CNT_W-1:0]         count;
  logic                     do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full        = (count == CNT_W'(DEPTH));
  assign empty       = (count == '0);
  assign do_push     = push & ~full;
  assign do_pop      = pop & ~empty;
  assign head_dest   = dest_q[rd_ptr];
  assign head_mask   = mask_q[rd_ptr];
  assign head_signed = signed_q[rd_ptr];

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dest_q[i]   <= '0;
        mask_q[i]   <= '0;
        signed_q[i] <= 1'b0;
      end
    end else begin
      if (do_pop) begin
        valid_q[rd_ptr] <= 1'b0;
        rd_ptr          <= next_ptr(rd_ptr);
      end
      if (do_push) begin
        valid_q[wr_ptr]  <= 1'b1;
        dest_q[wr_ptr]   <= push_dest;
        mask_q[wr_ptr]   <= push_mask;
        signed_q[wr_ptr] <= push_signed;
        wr_ptr           <= next_ptr(wr_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // r0 is never a real destination, so a zero select never reports busy
  always_comb begin
    cmp_hit = '0;
    for (int c = 0; c < NUM_CMP; c++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && (dest_q[i] == cmp_sel[c])) cmp_hit[c] = 1'b1;
      end
      if (cmp_sel[c] == '0) cmp_hit[c] = 1'b0;
    end
  end

endmodule

// File: rtl/slurm32_cpu_writeback_lq.sv
// SLURM32 stage-4 writeback: single registered write port, pending-load queue, skid register.
// Define SLURM32_WB_SCOREBOARD_QUERY_EN to add the query_sel_a/b -> query_busy load-use ports.
module slurm32_cpu_writeback_lq
  import slurm32_cpu_writeback_lq_pkg::*;
#(
  parameter int REGISTER_BITS    = 8,
  parameter int BITS             = 32,
  parameter int ADDRESS_BITS     = 32,
  parameter int LOAD_QUEUE_DEPTH = 2
) (
  input  logic                     CLK,
  input  logic                     RSTb,
  input  logic [BITS-1:0]          instruction,
  input  logic [BITS-1:0]          aluOut,
  input  logic [ADDRESS_BITS-1:0]  pc_stage4,
  input  logic                     nop_stage4,
  input  logic                     cond_pass,
  input  logic                     load_interrupt_return_address,
  input  logic [3:0]               memory_mask_delayed,
  input  logic [BITS-1:0]          memory_in,
  input  logic                     memory_valid,
  output logic                     stall,
  output logic                     reg_wr_en,
  output logic [REGISTER_BITS-1:0] reg_wr_sel,
  output logic [BITS-1:0]          reg_out,
  output logic                     wb_error
`ifdef SLURM32_WB_SCOREBOARD_QUERY_EN
  ,
  input  logic [REGISTER_BITS-1:0] query_sel_a,
  input  logic [REGISTER_BITS-1:0] query_sel_b,
  output logic [1:0]               query_busy
`endif
);

`ifdef SLURM32_WB_SCOREBOARD_QUERY_EN
  localparam int NUM_CMP = 3;
`else
  localparam int NUM_CMP = 1;
`endif

  wb_kind_t                              kind;
  logic                                  slot_valid, slot_is_load, accept, load_ret;
  logic                                  res_wr;
  logic [REGISTER_BITS-1:0]              res_sel;
  logic [BITS-1:0]                       res_data;
  logic [ADDRESS_BITS-3:0]               link_hi;
  logic                                  skid_valid;
  logic [REGISTER_BITS-1:0]              skid_sel;
  logic [BITS-1:0]                       skid_data;
  logic                                  q_full, q_empty;
  logic [REGISTER_BITS-1:0]              head_dest;
  logic [3:0]                            head_mask;
  logic                                  head_signed;
  logic [NUM_CMP-1:0][REGISTER_BITS-1:0] cmp_sel;
  logic [NUM_CMP-1:0]                    cmp_hit;

  assign kind       = classify_from_ins(instruction);
  assign link_hi    = pc_stage4[ADDRESS_BITS-1:2] + (ADDRESS_BITS-2)'(1);
  assign slot_valid = ~nop_stage4 | load_interrupt_return_address;

  always_comb begin
    res_wr       = 1'b0;
    res_sel      = '0;
    res_data     = aluOut;
    slot_is_load = 1'b0;
    if (load_interrupt_return_address) begin
      res_wr   = 1'b1;
      res_sel  = REGISTER_BITS'(INTERRUPT_LINK_REGISTER);
      res_data = BITS'(pc_stage4);
    end else if (!nop_stage4) begin
      case (kind)
        WB_SRC2: begin
          res_wr  = 1'b1;
          res_sel = REGISTER_BITS'(reg_src2_from_ins(instruction));
        end
        WB_DEST: begin
          res_wr  = 1'b1;
          res_sel = REGISTER_BITS'(reg_dest_from_ins(instruction));
        end
        WB_LINK: begin
          res_wr   = 1'b1;
          res_sel  = REGISTER_BITS'(LINK_REGISTER);
          res_data = BITS'({link_hi, 2'b00});
        end
        WB_COND_SRC: begin
          res_wr  = cond_pass;
          res_sel = REGISTER_BITS'(reg_src_from_ins(instruction));
        end
        WB_LOAD: slot_is_load = 1'b1;
        default: res_wr = 1'b0;
      endcase
    end
    if (res_sel == '0) res_wr = 1'b0;
  end

`ifdef SLURM32_WB_SCOREBOARD_QUERY_EN
  assign cmp_sel    = {query_sel_b, query_sel_a, res_sel};
  assign query_busy = cmp_hit[2:1];
`else
  assign cmp_sel    = res_sel;
`endif

  // Fullness and dest matches come from registered queue state, so a same-cycle pop never unstalls
  assign stall    = skid_valid
                  | (slot_valid & slot_is_load & q_full)
                  | (res_wr & cmp_hit[0]);
  assign accept   = slot_valid & ~stall;
  assign load_ret = memory_valid & ~q_empty;

  slurm32_wb_load_queue #(
    .REGISTER_BITS (REGISTER_BITS),
    .DEPTH         (LOAD_QUEUE_DEPTH),
    .NUM_CMP       (NUM_CMP)
  ) u_load_queue (
    .CLK         (CLK),
    .RSTb        (RSTb),
    .push        (accept & slot_is_load),
    .push_dest   (REGISTER_BITS'(reg_dest_from_ins(instruction))),
    .push_mask   (memory_mask_delayed),
    .push_signed (is_load_signed_from_ins(instruction)),
    .pop         (load_ret),
    .head_dest   (head_dest),
    .head_mask   (head_mask),
    .head_signed (head_signed),
    .full        (q_full),
    .empty       (q_empty),
    .cmp_sel     (cmp_sel),
    .cmp_hit     (cmp_hit)
  );

  // Write port: load return wins, then the skid entry, then the new stage-4 result
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      reg_wr_en  <= 1'b0;
      reg_wr_sel <= '0;
      reg_out    <= '0;
      skid_valid <= 1'b0;
      skid_sel   <= '0;
      skid_data  <= '0;
      wb_error   <= 1'b0;
    end else begin
      reg_wr_en <= 1'b0;
      if (memory_valid && q_empty) wb_error <= 1'b1;
      if (load_ret) begin
        reg_wr_en  <= (head_dest != '0);
        reg_wr_sel <= head_dest;
        reg_out    <= load_align(memory_in, head_mask, head_signed);
        if (accept && res_wr) begin
          skid_valid <= 1'b1;
          skid_sel   <= res_sel;
          skid_data  <= res_data;
        end
      end else if (skid_valid) begin
        reg_wr_en  <= 1'b1;
        reg_wr_sel <= skid_sel;
        reg_out    <= skid_data;
        skid_valid <= 1'b0;
      end else if (accept && res_wr) begin
        reg_wr_en  <= 1'b1;
        reg_wr_sel <= res_sel;
        reg_out    <= res_data;
      end
    end
  end

endmodule

// File: doc/slurm32_cpu_writeback_lq.md
# slurm32_cpu_writeback_lq

Pipeline stage-4 writeback unit for SLURM32 with a registered single write port, an in-order pending-load queue and load-data alignment. It retires ALU, branch-link, conditional-ALU and interrupt-link results, and completes memory loads whose data returns with variable latency. It arbitrates these writes onto the register file and stalls the pipeline on write-port or write-after-write conflicts.

## Interface
- REGISTER_BITS, 8: register select width.
- BITS, 32: datapath width; must be 32.
- ADDRESS_BITS, 32: PC width.
- LOAD_QUEUE_DEPTH, 2: number of outstanding loads, power of two, at least 1.
- CLK  in  1  clock; all state updates on the rising edge.
- RSTb  in  1  reset, asynchronous, active-low.
- instruction  in  BITS  instruction in stage 4.
- aluOut  in  BITS  ALU result for stage 4.
- pc_stage4  in  ADDRESS_BITS  PC of the stage-4 instruction.
- nop_stage4  in  1  stage-4 slot is NOP'd.
- cond_pass  in  1  the conditional instruction passed in stage 2.
- load_interrupt_return_address  in  1  write pc_stage4 to INTERRUPT_LINK_REGISTER.
- memory_mask_delayed  in  4  byte-lane mask of the stage-4 load.
- memory_in  in  BITS  load return data.
- memory_valid  in  1  memory_in is valid for the oldest pending load.
- stall  out  1  stage 4 must hold; the current slot is not consumed.
- reg_wr_en  out  1  register write strobe.
- reg_wr_sel  out  REGISTER_BITS  write register select.
- reg_out  out  BITS  write data.
- wb_error  out  1  sticky flag: memory_valid arrived with the queue empty.

## Operation
- Stage-4 slot is accepted when stall=0 and it carries a valid op. The slot is not consumed if nop_stage4=1 and load_interrupt_return_address=0.
- Slot classification, in priority order:
  - Interrupt: INTERRUPT_LINK_REGISTER ← pc_stage4.
  - Single-reg ALU: src2 ← aluOut.
  - Reg-reg and reg-imm ALU: dest ← aluOut.
  - Branch-and-link: LINK_REGISTER ← {pc_stage4[ADDRESS_BITS-1:2]+1, 2'b00}.
  - Conditional two-reg ALU with cond_pass=1: src ← aluOut.
  - Load: enqueue {dest, memory_mask_delayed, signed bit}.
  - Anything else: no write.
- Writes to r0 never assert reg_wr_en.
- Load extraction:
  - Mask 1111: full word.
  - Mask 0011 or 1100: the selected halfword.
  - One-hot mask: the selected byte.
  - Result is sign- or zero-extended according to the instruction.
  - Any other mask is treated as a full word.
- Write-port priority: load return > skid register > new stage-4 result.
- Skid register: one entry. It captures a non-load result that loses arbitration to a load return.
- stall = skid_valid OR (slot is a load AND queue full) OR (slot writes a register held as dest by any pending load; WAW guard).
- memory_valid with an empty queue: ignored, and wb_error is set.

## Timing
- Reset values: stall=0 with queue empty, reg_wr_en=0, reg_wr_sel=0, reg_out=0, wb_error=0, queue empty, skid empty.
- Outputs are registered. A stage-4 result appears one cycle after acceptance. Load data appears one cycle after memory_valid.
- stall is combinational from registered state and the stage-4 inputs.
- A load returning in the same cycle as a non-load slot: the load writes next cycle, the non-load result goes to the skid and writes the cycle after.
- Continuous memory_valid starves the skid for at most LOAD_QUEUE_DEPTH cycles, because no loads enter the queue while stall=1.
- Load enqueue and dequeue in the same cycle with the queue full: the pop makes room, but stall still follows registered fullness, so the enqueue waits one cycle.
- Queue pointers wrap modulo LOAD_QUEUE_DEPTH. Count width is clog2(depth)+1.
- RSTb asserted mid-operation: all pending loads are dropped immediately. The memory system is reset together with this block.

## Configuration
- SLURM32_WB_SCOREBOARD_QUERY_EN adds ports query_sel_a and query_sel_b (in, REGISTER_BITS) and query_busy (out, 2).
  - Each query_busy bit is combinationally 1 when its select matches a pending load dest and the select is non-zero.
  - This lets decode stall on load-use.
- Without the macro the ports are absent. The WAW guard is always present.

## Structure
- Shared decode include holds:
  - LINK_REGISTER and INTERRUPT_LINK_REGISTER.
  - The INSTRUCTION_CASEX_* patterns, plus a new INSTRUCTION_CASEX_LOAD.
  - reg_*_from_ins, is_branch_link_from_ins and a new is_load_signed_from_ins.
- Sub-module slurm32_wb_load_queue contains the FIFO, full/empty logic and the parallel dest-match compare used by both the WAW guard and the query ports.

## Test plan
- Reg-reg ALU with dest r5 and aluOut 0x1234 → next cycle reg_wr_en=1, sel=5, out=0x1234.
- BL at pc_stage4=0x100 → LINK_REGISTER written with 0x104. Interrupt with the same pc → INTERRUPT_LINK_REGISTER written with 0x100.
- Signed byte load with mask 0100 and memory_in=0x00800000 → out=0xFFFFFF80. Unsigned load with the same inputs → 0x00000080.
- Two loads queued (depth 2), then a third load → stall=1 until the first memory_valid. Data is returned in order.
- memory_valid in the same cycle as an ALU slot to r3 → load written first, r3 written the following cycle, stall high for one cycle.
- ALU slot targeting r7 while a load to r7 is pending → stall until the load writes back. memory_valid with the queue empty → wb_error=1 until reset.
